// File: rtl/synthesijer_fconv_f2d_buf.sv
// ---------------------------------------------------------------------------
// synthesijer_fconv_f2d_buf
//
// Flow-control and result buffer around a single-to-double conversion core.
// The core has no back-pressure and a fixed but unknown latency. This block
// issues a launch only when a result slot is already reserved, so a result
// can always be captured. Results are held in a small FIFO and presented
// with a ready/valid handshake. Each entry carries IEEE-754 class flags.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   req_a        single-precision operand from the datapath
//   req_nd       request strobe (taken when req_nd && req_ready)
//   req_ready    a request can be accepted this cycle
//   conv_a       registered operand to the converter
//   conv_nd      registered one-cycle launch strobe to the converter
//   conv_result  double-precision result from the converter
//   conv_valid   result strobe from the converter
//   dout         head-of-FIFO result (first-word fall-through)
//   dout_valid   FIFO not empty
//   dout_ready   consumer takes the head when dout_valid && dout_ready
//   dout_nan/inf/zero  class flags of the head entry
//   busy         conversions in flight or results buffered
//   err          sticky; set by a conv_valid with nothing in flight
// ---------------------------------------------------------------------------
module synthesijer_fconv_f2d_buf #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_a,
    input  logic        req_nd,
    output logic        req_ready,
    output logic [31:0] conv_a,
    output logic        conv_nd,
    input  logic [63:0] conv_result,
    input  logic        conv_valid,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_nan,
    output logic        dout_inf,
    output logic        dout_zero,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        nan;
        logic        inf;
        logic        zero;
        logic [63:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   count;

    logic [CW:0]     credit_used;
    logic            accept;
    logic            capture;
    logic            pop;
    logic            spurious;
    logic [10:0]     cap_exp;
    logic [51:0]     cap_man;
    entry_t          cap_entry;
    entry_t          head;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        credit_used = '0;
        cap_entry   = '0;
        head        = '0;

        // One extra bit so the sum of two CW-bit counters cannot wrap.
        credit_used = {1'b0, inflight} + {1'b0, count};
        req_ready   = credit_used < (CW+1)'(DEPTH);
        accept      = req_nd && req_ready;

        capture     = conv_valid && (inflight != '0);
        spurious    = conv_valid && (inflight == '0);

        dout_valid  = (count != '0);
        pop         = dout_valid && dout_ready;
        busy        = (inflight != '0) || (count != '0);

        // Class flags ignore the sign; denormals set no flag.
        cap_exp        = conv_result[62:52];
        cap_man        = conv_result[51:0];
        cap_entry.data = conv_result;
        cap_entry.nan  = (cap_exp == 11'h7FF) && (cap_man != '0);
        cap_entry.inf  = (cap_exp == 11'h7FF) && (cap_man == '0);
        cap_entry.zero = (cap_exp == 11'h000) && (cap_man == '0);

        // An empty FIFO presents zeros rather than a stale or unwritten slot.
        if (dout_valid) begin
            head = mem[rptr];
        end
        dout      = head.data;
        dout_nan  = head.nan;
        dout_inf  = head.inf;
        dout_zero = head.zero;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            conv_a   <= '0;
            conv_nd  <= 1'b0;
            inflight <= '0;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            err      <= 1'b0;
        end else begin
            conv_nd <= accept;
            if (accept) begin
                conv_a <= req_a;
            end

            // Launch and capture in the same cycle cancel out.
            unique case ({accept, capture})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            // Capture and pop in the same cycle cancel out.
            unique case ({capture, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (capture) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end

            // A result with nothing in flight is dropped and latched as an error.
            if (spurious) begin
                err <= 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; validity is tracked
    // by count and the pointers, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wptr] <= cap_entry;
        end
    end

endmodule

// File: tb/tb_synthesijer_fconv_f2d_buf.sv
module tb_synthesijer_fconv_f2d_buf;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int LAT   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_a;
    logic        req_nd;
    logic        req_ready;
    logic [31:0] conv_a;
    logic        conv_nd;
    logic [63:0] conv_result;
    logic        conv_valid;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_nan;
    logic        dout_inf;
    logic        dout_zero;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    synthesijer_fconv_f2d_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_a       (req_a),
        .req_nd      (req_nd),
        .req_ready   (req_ready),
        .conv_a      (conv_a),
        .conv_nd     (conv_nd),
        .conv_result (conv_result),
        .conv_valid  (conv_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_nan    (dout_nan),
        .dout_inf    (dout_inf),
        .dout_zero   (dout_zero),
        .busy        (busy),
        .err         (err)
    );

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
        logic        nan;
        logic        inf;
        logic        zero;
    } vec_t;

    vec_t        vecs [8];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] exp_q [$];
    logic        pipe_v [1:LAT];
    logic [63:0] pipe_d [1:LAT];
    int          accepts   = 0;
    int          pops      = 0;
    int          nd_pulses = 0;
    int          cv_pulses = 0;
    int          max_out   = 0;
    logic        pop_seen;
    logic [63:0] pop_d;
    logic [2:0]  pop_f;

    // Reference single-to-double conversion used by the converter model and
    // the scoreboard.
    function automatic logic [63:0] f2d(input logic [31:0] f);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [63:0] m64;
        int          p;
        s = f[31];
        e = f[30:23];
        m = f[22:0];
        if (e == 8'hFF) return {s, 11'h7FF, m, 29'b0};
        if (e == 8'h00) begin
            if (m == '0) return {s, 63'b0};
            p = 0;
            for (int i = 0; i < 23; i++) if (m[i]) p = i;
            m64 = {41'b0, m} << (52 - p);
            return {s, 11'(p + 874), m64[51:0]};
        end
        return {s, 11'({3'b0, e} + 11'd896), m, 29'b0};
    endfunction

    function automatic logic [2:0] cls(input logic [63:0] d);
        logic [10:0] e;
        logic [51:0] m;
        e = d[62:52];
        m = d[51:0];
        return {(e == 11'h7FF) && (m != '0), (e == 11'h7FF) && (m == '0),
                (e == 11'h000) && (m == '0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    // The converter model (fixed latency LAT, no reset) runs here.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        conv_valid  = pipe_v[LAT];
        conv_result = pipe_d[LAT];
        if (conv_valid) cv_pulses++;
        for (int i = LAT; i >= 2; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[1] = conv_nd;
        pipe_d[1] = f2d(conv_a);
        if (conv_nd) nd_pulses++;
    endtask

    // Drive one cycle of inputs, update the scoreboard, then advance.
    task automatic cycle(input logic nd, input logic [31:0] a, input logic rdy);
        logic [63:0] e;
        req_nd     = nd;
        req_a      = a;
        dout_ready = rdy;
        pop_seen   = 1'b0;
        if (nd && req_ready && !reset) begin
            exp_q.push_back(f2d(a));
            accepts++;
        end
        if (dout_valid && rdy && !reset) begin
            pop_seen = 1'b1;
            pop_d    = dout;
            pop_f    = {dout_nan, dout_inf, dout_zero};
            pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h expected no output (cycle %0d)", dout, cyc);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", dout, e);
                check("sb_flags", 64'(pop_f), 64'(cls(e)));
            end
        end
        if (accepts - pops > max_out) max_out = accepts - pops;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        accepts = 0;
        pops    = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_conv_nd"},   64'(conv_nd),   64'd0);
        check({tag, "_conv_a"},    64'(conv_a),    64'd0);
        check({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
        check({tag, "_dout"},      dout,           64'd0);
        check({tag, "_flags"},     64'({dout_nan, dout_inf, dout_zero}), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < limit) begin
            cycle(1'b0, 32'h0, 1'b1);
            n++;
        end
        check("drain_timeout", 64'(n >= limit), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t0;
        int          a0;
        int          p0;
        int          n0;
        int          c0;
        int          n;
        logic [63:0] held;
        logic        stable;
        logic        any_valid;

        vecs[0] = '{a: 32'h3F800000, d: 64'h3FF0000000000000, nan: 0, inf: 0, zero: 0};
        vecs[1] = '{a: 32'h7FC00000, d: 64'h7FF8000000000000, nan: 1, inf: 0, zero: 0};
        vecs[2] = '{a: 32'hFF800000, d: 64'hFFF0000000000000, nan: 0, inf: 1, zero: 0};
        vecs[3] = '{a: 32'h80000000, d: 64'h8000000000000000, nan: 0, inf: 0, zero: 1};
        vecs[4] = '{a: 32'h00000001, d: 64'h36A0000000000000, nan: 0, inf: 0, zero: 0};
        vecs[5] = '{a: 32'h40490FDB, d: 64'h400921FB60000000, nan: 0, inf: 0, zero: 0};
        vecs[6] = '{a: 32'h80400000, d: 64'hB800000000000000, nan: 0, inf: 0, zero: 0};
        vecs[7] = '{a: 32'h7F7FFFFF, d: 64'h47EFFFFFE0000000, nan: 0, inf: 0, zero: 0};

        for (int i = 1; i <= LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        conv_valid  = 1'b0;
        conv_result = '0;
        req_nd      = 1'b0;
        req_a       = '0;
        dout_ready  = 1'b0;
        reset       = 1'b1;
        tick();
        do_reset();
        check_reset_values("rst");

        // Single request: conv_nd at cycle 1, dout_valid at cycle 7.
        t0 = cyc;
        cycle(1'b1, 32'h3F800000, 1'b1);
        check("single_conv_nd", 64'(conv_nd), 64'd1);
        check("single_conv_a", 64'(conv_a), 64'h3F800000);
        n = 0;
        while (!dout_valid && n < 30) begin
            cycle(1'b0, 32'h0, 1'b1);
            n++;
        end
        check("single_latency", 64'(cyc - t0), 64'd7);
        check("single_dout", dout, 64'h3FF0000000000000);
        check("single_flags", 64'({dout_nan, dout_inf, dout_zero}), 64'd0);
        check("single_busy_before_pop", 64'(busy), 64'd1);
        cycle(1'b0, 32'h0, 1'b1);
        check("single_popped", 64'(pop_seen), 64'd1);
        check("single_busy_after_pop", 64'(busy), 64'd0);
        check("single_valid_after_pop", 64'(dout_valid), 64'd0);

        // Back-pressure: requests every cycle with the consumer stalled.
        a0 = accepts;
        n0 = nd_pulses;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h40000000 + 32'(i), 1'b0);
        check("bp_accepts", 64'(accepts - a0), 64'd4);
        check("bp_req_ready_low", 64'(req_ready), 64'd0);
        held   = '0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            if (dout_valid && held == '0) held = dout;
            else if (dout_valid && dout !== held) stable = 1'b0;
        end
        check("bp_conv_nd_pulses", 64'(nd_pulses - n0), 64'd4);
        check("bp_dout_stable", 64'(stable), 64'd1);
        check("bp_head", held, 64'h4000000000000000);
        check("bp_ready_before_pop", 64'(req_ready), 64'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("bp_first_pop", 64'(pop_seen), 64'd1);
        check("bp_ready_after_pop", 64'(req_ready), 64'd1);
        drain(50);

        // Class flags: table of vectors, one request each.
        foreach (vecs[k]) begin
            cycle(1'b1, vecs[k].a, 1'b1);
            n = 0;
            pop_seen = 1'b0;
            while (!pop_seen && n < 30) begin
                cycle(1'b0, 32'h0, 1'b1);
                n++;
            end
            check($sformatf("vec%0d_popped", k), 64'(pop_seen), 64'd1);
            check($sformatf("vec%0d_dout", k), pop_d, vecs[k].d);
            check($sformatf("vec%0d_flags", k), 64'(pop_f),
                  64'({vecs[k].nan, vecs[k].inf, vecs[k].zero}));
        end
        drain(50);

        // Streaming with a ready consumer: 100 random requests.
        a0 = accepts;
        p0 = pops;
        max_out = 0;
        n = 0;
        while (accepts - a0 < 100 && n < 2000) begin
            cycle(1'b1, $urandom, 1'b1);
            n++;
        end
        drain(100);
        check("stream_accepts", 64'(accepts - a0), 64'd100);
        check("stream_pops", 64'(pops - p0), 64'd100);
        check("stream_max_outstanding", 64'(max_out <= DEPTH), 64'd1);
        check("stream_err", 64'(err), 64'd0);

        // Spurious result with nothing in flight.
        conv_valid  = 1'b1;
        conv_result = 64'h1234567812345678;
        cycle(1'b0, 32'h0, 1'b1);
        check("spur_err", 64'(err), 64'd1);
        check("spur_valid", 64'(dout_valid), 64'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            any_valid = any_valid | dout_valid;
        end
        check("spur_err_sticky", 64'(err), 64'd1);
        check("spur_no_output", 64'(any_valid), 64'd0);
        do_reset();
        check("spur_err_cleared", 64'(err), 64'd0);

        // Reset with one result buffered and three in flight.
        cycle(1'b1, 32'h3F800000, 1'b0);
        n = 0;
        while (!dout_valid && n < 30) begin
            cycle(1'b0, 32'h0, 1'b0);
            n++;
        end
        check("mid_buffered", 64'(dout_valid), 64'd1);
        cycle(1'b1, 32'h40400000, 1'b0);
        cycle(1'b1, 32'h40800000, 1'b0);
        cycle(1'b1, 32'h40A00000, 1'b0);
        check("mid_third_launch", 64'(conv_nd), 64'd1);
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        accepts = 0;
        pops    = 0;
        check_reset_values("mid");
        c0 = cv_pulses;
        any_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            any_valid = any_valid | dout_valid;
        end
        check("mid_late_pulses", 64'(cv_pulses - c0), 64'd3);
        check("mid_err", 64'(err), 64'd1);
        check("mid_no_output", 64'(any_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
